// File: rtl/aibnd_dly_code_stepper.sv
// ---------------------------------------------------------------------------
// aibnd_dly_code_stepper
//
// Walks the gray-coded NAND delay-line code one LSB at a time from its
// current value toward a requested binary target. Each step drives the new
// code, lets it settle for SETTLE_CYC cycles, then strobes code_valid so the
// delay line latches it. Changing one gray bit per step keeps the delay
// change glitch-free on a live clock path.
//
// Ports:
//   ck          clock
//   rst         asynchronous reset, active-high
//   req         update request, only looked at while idle
//   target_code binary target code, captured together with req
//   abort       finish at the next step boundary
//   req_ack     one-cycle pulse when req is accepted
//   busy        high whenever a sequence is in progress
//   done        one-cycle pulse when a sequence ends
//   aborted     qualifies done: the sequence ended because of abort
//   cur_code    binary code currently driven
//   gray        registered gray code of cur_code, to the delay line
//   code_valid  one-cycle latch strobe to the delay line
// ---------------------------------------------------------------------------
module aibnd_dly_code_stepper #(
  parameter int CODE_W     = 7,
  parameter int MAX_CODE   = 64,
  parameter int RESET_CODE = 0,
  parameter int SETTLE_CYC = 4
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              req,
  input  logic [CODE_W-1:0] target_code,
  input  logic              abort,
  output logic              req_ack,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CODE_W-1:0] cur_code,
  output logic [CODE_W-1:0] gray,
  output logic              code_valid
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STEP   = 3'd1,
    SETTLE = 3'd2,
    PULSE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [CODE_W-1:0] MAX_C    = CODE_W'(MAX_CODE);
  localparam logic [CODE_W-1:0] RST_C    = CODE_W'(RESET_CODE);
  localparam logic [3:0]        CNT_LAST = 4'(SETTLE_CYC - 1);

  state_t            state;
  state_t            state_n;
  logic [3:0]        cnt;
  logic [CODE_W-1:0] tgt;
  logic [CODE_W-1:0] nxt_code;
  logic              abort_pend;

  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CODE_W-1:0] clamp_code(input logic [CODE_W-1:0] c);
    return (c > MAX_C) ? MAX_C : c;
  endfunction

  // tgt never exceeds MAX_CODE, so stepping toward it cannot leave 0..MAX_CODE
  assign nxt_code = (tgt > cur_code) ? cur_code + 1'b1 : cur_code - 1'b1;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (req) state_n = (clamp_code(target_code) == cur_code) ? DONE : STEP;
      STEP:    state_n = SETTLE;
      SETTLE:  if (cnt == CNT_LAST) state_n = PULSE;
      // abort arriving in the PULSE cycle itself still ends the sequence here
      PULSE:   state_n = (cur_code == tgt || abort_pend || abort) ? DONE : STEP;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      cur_code   <= RST_C;
      gray       <= bin2gray(RST_C);
      abort_pend <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        STEP: begin
          cur_code <= nxt_code;
          gray     <= bin2gray(nxt_code);
          cnt      <= 4'd0;
        end
        SETTLE: if (cnt != CNT_LAST) cnt <= cnt + 4'd1;
        default: ;
      endcase
      if (state == DONE)
        abort_pend <= 1'b0;
      else if (state != IDLE && abort)
        abort_pend <= 1'b1;
    end
  end

  // Target register carries no reset; it is always loaded before use.
  always_ff @(posedge ck) begin
    if (state == IDLE && req) tgt <= clamp_code(target_code);
  end

  assign req_ack    = (state == IDLE) && req;
  assign busy       = (state != IDLE);
  assign code_valid = (state == PULSE);
  assign done       = (state == DONE);
  assign aborted    = (state == DONE) && abort_pend;

endmodule

// File: tb/tb_aibnd_dly_code_stepper.sv
module tb_aibnd_dly_code_stepper;

  localparam int W = 7;
  localparam int MAXC = 64;
  localparam int S = 4;
  localparam int P = S + 2;

  logic         ck = 1'b0;
  logic         rst = 1'b1;
  logic         req = 1'b0;
  logic [W-1:0] target_code = '0;
  logic         abort = 1'b0;
  logic         req_ack, busy, done, aborted, code_valid;
  logic [W-1:0] cur_code, gray;

  aibnd_dly_code_stepper #(.CODE_W(W), .MAX_CODE(MAXC), .RESET_CODE(0), .SETTLE_CYC(S)) dut (
    .ck(ck), .rst(rst), .req(req), .target_code(target_code), .abort(abort),
    .req_ack(req_ack), .busy(busy), .done(done), .aborted(aborted),
    .cur_code(cur_code), .gray(gray), .code_valid(code_valid)
  );

  always #5 ck = ~ck;

  int cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    int at_cyc;
    int code;
    bit ab;
  } ev_t;

  ev_t q[$];
  int  tests = 0;
  int  fails = 0;
  int  model_code = 0;
  logic [W-1:0] prev_gray = '0;

  function automatic int g_of(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes code_valid or done.
  always @(negedge ck) begin
    if (rst) begin
      prev_gray <= gray;
    end else begin
      if (cur_code > MAXC) chk("code_range", int'(cur_code), MAXC);
      if (gray != prev_gray) begin
        chk("gray_one_bit", $countones(gray ^ prev_gray), 1);
        prev_gray <= gray;
      end
      if (code_valid || done) begin
        if (q.size() == 0) begin
          chk("unexpected_event", int'({code_valid, done}), 0);
        end else begin
          ev_t e;
          e = q.pop_front();
          chk(e.is_done ? "done_kind" : "pulse_kind", int'(done), int'(e.is_done));
          chk(e.is_done ? "done_cycle" : "pulse_cycle", cyc, e.at_cyc);
          chk("code", int'(cur_code), e.code);
          chk("gray", int'(gray), g_of(e.code));
          if (e.is_done) chk("aborted", int'(aborted), int'(e.ab));
        end
      end else if (aborted) begin
        chk("aborted_without_done", 1, 0);
      end
    end
  end

  // Issue one request; abort_off is the cycle offset (from the ack cycle) at
  // which abort is held for one cycle, -1 for none. probe drives a second req
  // while busy, which must not be acknowledged.
  task automatic run_req(input int tgt_in, input int abort_off, input bit probe);
    int c0, tgt, n, dir, ns, off;
    bit ab;
    @(posedge ck); #1;
    req = 1'b1;
    target_code = W'(tgt_in);
    abort = (abort_off == 0);
    @(negedge ck);
    chk("req_ack", int'(req_ack), 1);
    c0 = cyc;
    tgt = (tgt_in > MAXC) ? MAXC : tgt_in;
    n = (tgt > model_code) ? tgt - model_code : model_code - tgt;
    dir = (tgt > model_code) ? 1 : -1;
    if (abort_off >= 1 && abort_off <= n * P) begin
      ns = (abort_off + P - 1) / P;
      ab = 1'b1;
    end else begin
      ns = n;
      ab = 1'b0;
    end
    for (int k = 1; k <= ns; k++)
      q.push_back('{is_done: 1'b0, at_cyc: c0 + k * P, code: model_code + dir * k, ab: 1'b0});
    model_code = model_code + dir * ns;
    q.push_back('{is_done: 1'b1, at_cyc: c0 + ns * P + 1, code: model_code, ab: ab});
    off = 1;
    @(posedge ck); #1;
    req = 1'b0;
    forever begin
      abort = (off == abort_off);
      req = probe && (off == 2) && (ns >= 1);
      @(negedge ck);
      if (req) chk("busy_req_ack", int'(req_ack), 0);
      if (!busy) break;
      if (off > 1000) begin
        chk("busy_timeout", off, -1);
        break;
      end
      @(posedge ck); #1;
      off++;
    end
    chk("idle_return", cyc - c0, ns * P + 2);
    req = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int t, a, n;
    repeat (3) @(negedge ck);
    chk("rst_cur", int'(cur_code), 0);
    chk("rst_gray", int'(gray), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cv", int'(code_valid), 0);
    chk("rst_done", int'(done), 0);
    @(posedge ck); #1 rst = 1'b0;

    run_req(3, -1, 1'b0);
    run_req(1, -1, 1'b0);
    run_req(100, -1, 1'b0);
    chk("clamp_cur", int'(cur_code), 64);
    chk("clamp_gray", int'(gray), 7'b110_0000);
    run_req(64, -1, 1'b0);            // equal target
    run_req(0, -1, 1'b0);
    run_req(10, P + 3, 1'b1);         // abort in SETTLE of the 2nd step
    chk("abort_cur", int'(cur_code), 2);
    run_req(4, 2 * P, 1'b0);          // abort on the final PULSE
    run_req(6, 0, 1'b0);              // abort together with req in IDLE

    // asynchronous reset in the middle of SETTLE
    @(posedge ck); #1;
    req = 1'b1; target_code = W'(20);
    @(posedge ck); #1 req = 1'b0;
    repeat (3) @(posedge ck);
    #3 rst = 1'b1;
    #1;
    chk("arst_cur", int'(cur_code), 0);
    chk("arst_gray", int'(gray), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_cv", int'(code_valid), 0);
    q.delete();
    model_code = 0;
    repeat (2) @(posedge ck);
    #2 rst = 1'b0;
    run_req(5, -1, 1'b0);
    chk("post_rst_cur", int'(cur_code), 5);

    for (int i = 0; i < 30; i++) begin
      t = $urandom_range(0, 127);
      n = (((t > MAXC) ? MAXC : t) > model_code) ? ((t > MAXC) ? MAXC : t) - model_code
                                                 : model_code - ((t > MAXC) ? MAXC : t);
      a = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n * P + 2) : -1;
      run_req(t, a, 1'($urandom_range(0, 1)));
      chk("rand_cur", int'(cur_code), model_code);
    end

    repeat (3) @(negedge ck);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
